// File: rtl/data_bus_mmio_pkg.sv
// Shared definitions for the data-bus MMIO bridge.
// Holds the IO register offsets, STATUS bit positions and the default IO
// window base. The firmware header generator reads these same values.
package data_bus_mmio_pkg;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_FF00;

   localparam logic [7:0] IO_OFS_LED    = 8'h00;
   localparam logic [7:0] IO_OFS_TXDATA = 8'h04;
   localparam logic [7:0] IO_OFS_STATUS = 8'h08;
   localparam logic [7:0] IO_OFS_CYCLE  = 8'h0C;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_COUNT_LSB = 4;

   // Accesses are word-only, so decode compares the word index and drops
   // the byte-lane bits.
   function automatic logic [5:0] wordIdx(input logic [7:0] ofs);
      return ofs[7:2];
   endfunction

endpackage

// File: rtl/data_bus_mmio_tx_fifo.sv
// Transmit byte FIFO for the MMIO bridge.
// Ports:
//   clk, rst        clock and synchronous active-high reset (pointers only)
//   push, pushData  enqueue request and byte
//   pop             dequeue request (ignored while empty)
//   head            entry at the read pointer
//   empty, full     occupancy flags
//   count           number of stored entries (wp - rp)
module mmio_tx_fifo #(
   parameter int FIFO_DEPTH = 4,
   localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [7:0]       pushData,
   input  logic             pop,
   output logic [7:0]       head,
   output logic             empty,
   output logic             full,
   output logic [PTR_W:0]   count
);

   logic [7:0]   mem [FIFO_DEPTH];
   logic [PTR_W:0] wp;
   logic [PTR_W:0] rp;
   logic         popOk;
   logic         pushOk;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count  = wp - rp;
   assign empty  = (count == '0);
   assign full   = (count == (PTR_W + 1)'(FIFO_DEPTH));
   assign head   = mem[rp[PTR_W-1:0]];
   assign popOk  = pop && !empty;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign pushOk = push && (!full || popOk);

   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (pushOk) wp <= wp + 1'b1;
         if (popOk)  rp <= rp + 1'b1;
      end
   end

   // Storage is deliberately not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && pushOk) mem[wp[PTR_W-1:0]] <= pushData;
   end

endmodule

// File: rtl/data_bus_mmio.sv
// Data-bus bridge behind the CPU MEM stage. Routes each access to external
// data RAM or to a 256-byte IO window (LED, TX FIFO, STATUS, cycle counter).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpuAddr/cpuWrData/cpuMemWrite  CPU data access
//   cpuRdData                      combinational load data
//   ramAddr/ramWrData/ramWrite     RAM pass-through, write masked for IO
//   ramRdData                      asynchronous RAM read data
//   ledOut                         LED register
//   txData/txValid/txReady         TX byte stream from the FIFO head
module data_bus_mmio
   import data_bus_mmio_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE = ADDR_WIDTH'(IO_BASE_DEFAULT),
   parameter int FIFO_DEPTH = 4,
   parameter int LED_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cpuAddr,
   input  logic [DATA_WIDTH-1:0] cpuWrData,
   input  logic                  cpuMemWrite,
   output logic [DATA_WIDTH-1:0] cpuRdData,
   output logic [ADDR_WIDTH-1:0] ramAddr,
   output logic [DATA_WIDTH-1:0] ramWrData,
   output logic                  ramWrite,
   input  logic [DATA_WIDTH-1:0] ramRdData,
   output logic [LED_WIDTH-1:0]  ledOut,
   output logic [7:0]            txData,
   output logic                  txValid,
   input  logic                  txReady
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic                  ioSel;
   logic [5:0]            ioWord;
   logic                  ioWrite;
   logic                  wrLed;
   logic                  wrTx;
   logic                  wrStatus;
   logic                  wrCycle;
   logic [LED_WIDTH-1:0]  led;
   logic [DATA_WIDTH-1:0] cycleCnt;
   logic                  ovf;
   logic                  txPop;
   logic                  fifoEmpty;
   logic                  fifoFull;
   logic [PTR_W:0]        fifoCount;
   logic [DATA_WIDTH-1:0] statusWord;
   logic                  ovfSet;
   logic                  ovfClr;

   assign ioSel   = (cpuAddr[ADDR_WIDTH-1:8] == IO_BASE[ADDR_WIDTH-1:8]);
   assign ioWord  = cpuAddr[7:2];
   assign ioWrite = cpuMemWrite && ioSel;

   assign wrLed    = ioWrite && (ioWord == wordIdx(IO_OFS_LED));
   assign wrTx     = ioWrite && (ioWord == wordIdx(IO_OFS_TXDATA));
   assign wrStatus = ioWrite && (ioWord == wordIdx(IO_OFS_STATUS));
   assign wrCycle  = ioWrite && (ioWord == wordIdx(IO_OFS_CYCLE));

   assign ramAddr   = cpuAddr;
   assign ramWrData = cpuWrData;
   assign ramWrite  = cpuMemWrite && !ioSel;

   assign txValid = !fifoEmpty;
   assign txPop   = txValid && txReady;

   mmio_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) uTxFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (wrTx),
      .pushData (cpuWrData[7:0]),
      .pop      (txPop),
      .head     (txData),
      .empty    (fifoEmpty),
      .full     (fifoFull),
      .count    (fifoCount)
   );

   // A drop only happens when the FIFO is full and the head is not leaving.
   assign ovfSet = wrTx && fifoFull && !txPop;
   assign ovfClr = wrStatus && cpuWrData[ST_OVF];

   always_ff @(posedge clk) begin
      if (rst) begin
         led      <= '0;
         cycleCnt <= '0;
         ovf      <= 1'b0;
      end else begin
         if (wrLed) led <= cpuWrData[LED_WIDTH-1:0];
         if (wrCycle) cycleCnt <= cpuWrData;
         else         cycleCnt <= cycleCnt + 1'b1;
         if (ovfSet)      ovf <= 1'b1;
         else if (ovfClr) ovf <= 1'b0;
      end
   end

   assign ledOut = led;

   always_comb begin
      statusWord = '0;
      statusWord[ST_EMPTY] = fifoEmpty;
      statusWord[ST_FULL]  = fifoFull;
      statusWord[ST_OVF]   = ovf;
      statusWord[ST_COUNT_LSB +: PTR_W + 1] = fifoCount;
   end

   always_comb begin
      cpuRdData = '0;
      if (!ioSel) begin
         cpuRdData = ramRdData;
      end else begin
         case (ioWord)
            wordIdx(IO_OFS_LED):    cpuRdData = DATA_WIDTH'(led);
            wordIdx(IO_OFS_STATUS): cpuRdData = statusWord;
            wordIdx(IO_OFS_CYCLE):  cpuRdData = cycleCnt;
            default:                cpuRdData = '0;
         endcase
      end
   end

endmodule

// File: doc/data_bus_mmio.md
Name: data_bus_mmio

Overview:
- Data-bus bridge directly downstream of the pipelined CPU's MEM stage. It consumes the CPU's data address, write data and write strobe.
- Routes each access either to the external data RAM or to a small memory-mapped IO block:
  - LED register
  - transmit byte FIFO with valid/ready output stream
  - status register
  - free-running cycle counter
- Returns read data combinationally in the same cycle, so the CPU's MEM/WB register captures it.

Parameters:
- DATA_WIDTH, 32, width of CPU data bus and all IO registers.
- ADDR_WIDTH, 32, width of CPU data address.
- IO_BASE, 32'h0000_FF00, base of the 256-byte IO window. Only bits [ADDR_WIDTH-1:8] are compared.
- FIFO_DEPTH, 4, TX FIFO entries. Must be a power of two, at least 2.
- LED_WIDTH, 8, LED register width.

Ports:
- clk  in  1  clock. One clock domain; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpuAddr  in  ADDR_WIDTH  byte address from CPU MEM stage.
- cpuWrData  in  DATA_WIDTH  store data from CPU.
- cpuMemWrite  in  1  store strobe from CPU.
- cpuRdData  out  DATA_WIDTH  load data to CPU. Combinational.
- ramAddr  out  ADDR_WIDTH  RAM address. Equals cpuAddr.
- ramWrData  out  DATA_WIDTH  RAM write data. Equals cpuWrData.
- ramWrite  out  1  RAM write enable.
- ramRdData  in  DATA_WIDTH  RAM asynchronous read data.
- ledOut  out  LED_WIDTH  LED register contents.
- txData  out  8  FIFO head byte.
- txValid  out  1  FIFO non-empty.
- txReady  in  1  downstream consumer accepts the head byte.

Behaviour:
- Decode:
  - ioSel = (cpuAddr[ADDR_WIDTH-1:8] == IO_BASE[ADDR_WIDTH-1:8]).
  - Offset = cpuAddr[7:0]. Bits [1:0] are ignored (word access only).
- RAM path:
  - ramWrite = cpuMemWrite && !ioSel.
  - cpuRdData = ramRdData when !ioSel.
  - No RAM write ever occurs for an IO address.
- IO map (offset: read / write):
  - 0x00 LED: read {0, led}; write led <= cpuWrData[LED_WIDTH-1:0].
  - 0x04 TXDATA: read 0; write pushes cpuWrData[7:0] into the FIFO.
  - 0x08 STATUS:
    - read bit0 empty, bit1 full, bit2 overflow (sticky), bits[7:4] occupancy count, rest 0.
    - write with cpuWrData[2]=1 clears overflow; other bits are ignored.
  - 0x0C CYCLE: read the current counter value; write loads the counter with cpuWrData.
  - Any other offset: read 0; write ignored.
- Reads are side-effect free and combinational. Reads return pre-edge state.
  - A STATUS read in the same cycle as a push shows the state before that push.
- Cycle counter:
  - Increments by 1 every cycle; wraps 2^32-1 -> 0.
  - A CYCLE write in a cycle loads cpuWrData at that edge instead of incrementing.
  - The cycle after the load, it reads the loaded value.
- FIFO:
  - Circular buffer; read and write pointers each have log2(FIFO_DEPTH)+1 bits.
  - count = wp - rp.
  - pop = txValid && txReady.
  - push = write to TXDATA.
  - Push accepted if not full, or if full with a pop in the same cycle.
  - Push when full with no pop: byte dropped, overflow <= 1, pointers unchanged.
  - Simultaneous push and pop when empty: the push is accepted and nothing pops, since txValid=0.
  - txData is the head entry. It is stable while txValid=1 and txReady=0.
- Overflow flag:
  - A clear and a new overflow in the same cycle: set wins.
- Reset (synchronous, rst=1 at an edge):
  - led=0, counter=0, FIFO empty (wp=rp=0), overflow=0.
  - Hence txValid=0 and ledOut=0 from the cycle after that edge.
  - FIFO storage contents are not reset.
- Reset mid-operation:
  - Pending FIFO bytes are discarded.
  - CPU writes in the reset cycle are ignored for IO registers.
  - ramWrite still follows its combinational rule.
- Latency:
  - IO write effects are visible one cycle after the edge.
  - txValid rises one cycle after the accepted push.

Decomposition:
- Shared package holds:
  - IO offsets: IO_OFS_LED, IO_OFS_TXDATA, IO_OFS_STATUS, IO_OFS_CYCLE.
  - STATUS bit positions: ST_EMPTY, ST_FULL, ST_OVF, ST_COUNT_LSB.
  - Default IO_BASE.
  - These are shared with the firmware header generator.
- One sub-module: mmio_tx_fifo.
  - Parameters: FIFO_DEPTH, 8-bit payload.
  - Ports: push, pushData, pop, head, empty, full, count.
- Decode, registers, counter and overflow logic live in data_bus_mmio.

Test Plan:
- After reset, read IO_BASE+0x08 -> 32'h0000_0001 (empty); ledOut=0, txValid=0.
- Store 32'h0000_01A5 to IO_BASE+0x00 -> next cycle ledOut=8'hA5, load of 0x00 returns 32'h0000_00A5, ramWrite stays 0.
- Store 32'hDEAD_BEEF to address 0x0000_0010 -> ramWrite=1, ramAddr=0x10, ramWrData=DEADBEEF; a load from 0x10 returns ramRdData unchanged.
- FIFO flow and overflow, txReady=0:
  - Push 0x11,0x22,0x33,0x44 -> STATUS=0x42 (full, count 4).
  - Push 0x55 -> dropped, STATUS=0x46.
  - Raise txReady -> txData 0x11,0x22,0x33,0x44 on consecutive cycles, then txValid=0.
  - Store 0x4 to STATUS -> overflow clears, STATUS=0x01.
- FIFO full with txReady=1 and push of 0x66 in the same cycle -> 0x11 pops, 0x66 is accepted, count stays 4, no overflow.
- Cycle counter:
  - Store 32'hFFFF_FFFE to CYCLE -> next-cycle read FFFF_FFFE, then FFFF_FFFF, then 0000_0000.
  - Assert rst mid-stream with 2 bytes queued -> txValid=0 and counter=0 after the reset edge.
